// File: rtl/dpe_pkg.sv
// dpe_pkg: shared definitions for the DPE stream blocks.
//   DPE_DATA_W / DPE_KEEP_W : DPE beat width and lane count
//   dpe_tuser_t             : per-beat sideband carried with tuser
//   ser_state_e             : byte serializer control states
package dpe_pkg;
  localparam int DPE_DATA_W = 128;
  localparam int DPE_KEEP_W = 16;

  typedef struct packed {
    logic       bypass_all;
    logic       bypass_stage;
    logic [2:0] src;
    logic [2:0] dst;
  } dpe_tuser_t;

  typedef enum logic [1:0] {IDLE, SEND, DROP} ser_state_e;
endpackage

// File: rtl/dpe_keep_penc.sv
// dpe_keep_penc: combinational lowest-set-bit encoder for a lane mask.
//   mask     in  W          lane mask
//   idx      out clog2(W)   index of lowest set bit (0 when mask is empty)
//   any      out 1          mask has at least one bit set
//   last_one out 1          exactly one bit set
module dpe_keep_penc import dpe_pkg::*; #(
  parameter int W  = DPE_KEEP_W,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          last_one
);
  // Scan downward so the lowest set bit is the final assignment.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--)
      if (mask[i]) idx = IW'(i);
  end

  assign any      = |mask;
  // Clearing the lowest set bit leaves zero only for a single-bit mask.
  assign last_one = any && ((mask & (mask - 1'b1)) == '0);
endmodule

// File: rtl/dpe_tx_byte_serializer.sv
// dpe_tx_byte_serializer: DPE AXI-Stream sink that holds one beat and emits
// its valid lanes one byte per cycle, lowest lane first, toward a MAC.
// Optional build macro: DPE_TX_SER_STATS_EN adds packet/byte/drop counters.
//   clk, rst                 clock, synchronous active-high reset
//   s_t*                     DPE beat input (valid/ready, data, last, keep,
//                            tuser fields, tid)
//   m_tvalid/m_tready        byte output handshake
//   m_tdata, m_tlast         byte and end-of-packet marker
//   m_src, m_tid             sideband latched at start of packet
//   err_zero_last            pulse: tlast beat carried an empty keep mask
//   drop_pkt                 pulse: packet addressed to another port
//   stat_clr, stat_*         (stats build only) counter clear and counters
module dpe_tx_byte_serializer import dpe_pkg::*; #(
  parameter int         KEEP_W  = DPE_KEEP_W,
  parameter logic [2:0] PORT_ID = 3'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [8*KEEP_W-1:0]   s_tdata,
  input  logic                  s_tlast,
  input  logic [KEEP_W-1:0]     s_tkeep,
  input  logic                  s_tuser_bypass_all,
  input  logic                  s_tuser_bypass_stage,
  input  logic [2:0]            s_tuser_src,
  input  logic [2:0]            s_tuser_dst,
  input  logic [7:0]            s_tid,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [7:0]            m_tdata,
  output logic                  m_tlast,
  output logic [2:0]            m_src,
  output logic [7:0]            m_tid,
  output logic                  err_zero_last,
  output logic                  drop_pkt
`ifdef DPE_TX_SER_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [31:0]           stat_pkts,
  output logic [31:0]           stat_bytes,
  output logic [15:0]           stat_drops
`endif
);
  localparam int IW = $clog2(KEEP_W);

  ser_state_e               state_q, state_d;
  logic [KEEP_W-1:0][7:0]   data_q, data_d;
  logic [KEEP_W-1:0]        rem_q, rem_d;
  logic                     last_q, last_d;
  logic                     sop_q, sop_d;
  logic                     drop_q, drop_d, err_q, err_d;
  logic [2:0]               src_q;
  logic [7:0]               tid_q;
  logic [IW-1:0]            idx;
  logic                     any, last_one;
  logic                     s_fire, m_fire;
  dpe_tuser_t               tuser;

  assign tuser = '{bypass_all:   s_tuser_bypass_all,
                   bypass_stage: s_tuser_bypass_stage,
                   src:          s_tuser_src,
                   dst:          s_tuser_dst};

  dpe_keep_penc #(.W(KEEP_W)) u_penc (
    .mask     (rem_q),
    .idx      (idx),
    .any      (any),
    .last_one (last_one)
  );

  // Bypass flags have no role in this sink.
  logic unused;
  assign unused = &{1'b0, any, tuser.bypass_all, tuser.bypass_stage};

  assign m_tvalid = (state_q == SEND);
  assign m_fire   = m_tvalid && m_tready;
  // Take the next beat in the same cycle the final byte of the held beat
  // leaves, so consecutive beats stream without a bubble.
  assign s_tready = !rst && (state_q == IDLE || state_q == DROP ||
                             (state_q == SEND && last_one && m_tready));
  assign s_fire   = s_tvalid && s_tready;

  assign m_tdata       = m_tvalid ? data_q[idx] : 8'h00;
  assign m_tlast       = m_tvalid && last_q && last_one;
  assign m_src         = src_q;
  assign m_tid         = tid_q;
  assign err_zero_last = err_q;
  assign drop_pkt      = drop_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    last_d  = last_q;
    sop_d   = sop_q;
    drop_d  = 1'b0;
    err_d   = 1'b0;
    if (m_fire) begin
      rem_d = rem_q & (rem_q - 1'b1);
      if (last_one) state_d = IDLE;
    end
    if (s_fire) begin
      sop_d = s_tlast;
      if (sop_q && tuser.dst != PORT_ID) begin
        drop_d  = 1'b1;
        state_d = s_tlast ? IDLE : DROP;
      end else if (state_q == DROP) begin
        if (s_tlast) state_d = IDLE;
      end else if (s_tkeep == '0) begin
        // An empty tlast beat still emits lane 0 so the MAC frame closes.
        // An empty non-last beat emits nothing; state_d is already IDLE.
        if (s_tlast) begin
          err_d   = 1'b1;
          data_d  = s_tdata;
          rem_d   = KEEP_W'(1);
          last_d  = 1'b1;
          state_d = SEND;
        end
      end else begin
        data_d  = s_tdata;
        rem_d   = s_tkeep;
        last_d  = s_tlast;
        state_d = SEND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      sop_q   <= 1'b1;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      src_q   <= '0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      sop_q   <= sop_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      if (s_fire && sop_q) begin
        src_q <= tuser.src;
        tid_q <= s_tid;
      end
    end
  end

`ifdef DPE_TX_SER_STATS_EN
  // Clear dominates any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_pkts  <= '0;
      stat_bytes <= '0;
      stat_drops <= '0;
    end else begin
      if (m_fire)            stat_bytes <= stat_bytes + 32'd1;
      if (m_fire && m_tlast) stat_pkts  <= stat_pkts + 32'd1;
      if (drop_q)            stat_drops <= stat_drops + 16'd1;
    end
  end
`endif
endmodule
